// File: rtl/logic_result_fifo_if.sv
// Handshake bundle between the 2-bit logic unit, the result FIFO and the
// display/consumer stage.
interface logic_result_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic       op_sel;
  logic [3:0] nand_AB;
  logic [3:0] not_A;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_op;

  // Producer and consumer side, driven by the logic unit / display stage
  modport master (
    output in_valid,
    output op_sel,
    output nand_AB,
    output not_A,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_op
  );

  // FIFO side
  modport slave (
    input  in_valid,
    input  op_sel,
    input  nand_AB,
    input  not_A,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_op
  );
endinterface

// File: rtl/logic_result_fifo.sv
// First-word-fall-through result FIFO behind the 2-bit logic unit: captures
// the NAND or NOT result with its op tag and hands it on via valid/ready.
module logic_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_result_fifo_if.slave   bus,
  output logic [PTR_W:0]       level,
  output logic [CNT_W-1:0]     accepted
);

  localparam int              DATA_W   = 4;
  localparam logic [PTR_W:0]  LVL_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_t;

  fifo_state_t       fifo_state;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_op   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] din;
  logic              tag;
  logic              push;
  logic              pop;

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Occupancy class is decoded from the registered level only, so in_ready
  // never depends combinationally on out_ready.
  always_comb begin
    fifo_state = ST_PARTIAL;
    if (level == '0) begin
      fifo_state = ST_EMPTY;
    end else if (level == LVL_FULL) begin
      fifo_state = ST_FULL;
    end
  end

  assign bus.in_ready  = (fifo_state != ST_FULL);
  assign bus.out_valid = (fifo_state != ST_EMPTY);

  assign din  = bus.op_sel ? bus.not_A : bus.nand_AB;
  assign tag  = bus.op_sel;
  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.out_data = bus.out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_op   = bus.out_valid ? mem_op[rd_ptr]   : 1'b0;

  // Storage: data only, never reset; stale entries are unreachable once
  // the pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= din;
      mem_op[wr_ptr]   <= tag;
    end
  end

  // Control: pointers, occupancy and accepted counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      accepted <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        accepted <= sat_inc(accepted);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_result_fifo.sv
// Self-checking bench for logic_result_fifo: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_logic_result_fifo;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 8;
  localparam int CNT_W1 = 3;

  typedef struct packed {
    logic       op;
    logic [3:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PTR_W:0]    level0, level1;
  logic [CNT_W-1:0]  accepted0;
  logic [CNT_W1-1:0] accepted1;

  int total = 0;
  int bad   = 0;

  ent_t        q0[$];
  ent_t        q1[$];
  int unsigned acc0;
  int unsigned acc1;

  logic_result_fifo_if bus0();
  logic_result_fifo_if bus1();

  logic_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus0),
    .level    (level0),
    .accepted (accepted0)
  );

  logic_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus1),
    .level    (level1),
    .accepted (accepted1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge; both reference models follow the FIFO rules on the
  // values present just before the edge.
  task automatic tick();
    logic p0, r0, p1, r1;
    ent_t e0, e1;
    p0   = bus0.in_valid && (q0.size() < DEPTH);
    r0   = bus0.out_ready && (q0.size() != 0);
    e0.op = bus0.op_sel;
    e0.d  = bus0.op_sel ? bus0.not_A : bus0.nand_AB;
    p1   = bus1.in_valid && (q1.size() < DEPTH);
    r1   = bus1.out_ready && (q1.size() != 0);
    e1.op = bus1.op_sel;
    e1.d  = bus1.op_sel ? bus1.not_A : bus1.nand_AB;
    @(posedge clk);
    #1;
    if (rst) begin
      q0.delete(); acc0 = 0;
      q1.delete(); acc1 = 0;
    end else begin
      if (r0) void'(q0.pop_front());
      if (p0) begin q0.push_back(e0); if (acc0 < 255) acc0++; end
      if (r1) void'(q1.pop_front());
      if (p1) begin q1.push_back(e1); if (acc1 < 7) acc1++; end
    end
  endtask

  task automatic drive0(input logic v, input logic op, input logic [3:0] n, input logic [3:0] a);
    bus0.in_valid = v;
    bus0.op_sel   = op;
    bus0.nand_AB  = n;
    bus0.not_A    = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (level0 !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level0); end
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus0.out_valid); end
    total++; if (bus0.out_data !== 4'd0) begin bad++; $display("FAIL reset_out_data got=%b exp=0000", bus0.out_data); end
    total++; if (bus0.out_op !== 1'b0) begin bad++; $display("FAIL reset_out_op got=%b exp=0", bus0.out_op); end
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready); end
    total++; if (accepted0 !== 8'd0) begin bad++; $display("FAIL reset_accepted got=%0d exp=0", accepted0); end
  endtask

  task automatic test_single_push();
    do_reset();
    drive0(1'b1, 1'b0, 4'b0001, 4'b1001);
    tick();
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", bus0.out_valid); end
    total++; if (bus0.out_data !== 4'b0001) begin bad++; $display("FAIL single_out_data got=%b exp=0001", bus0.out_data); end
    total++; if (bus0.out_op !== 1'b0) begin bad++; $display("FAIL single_out_op got=%b exp=0", bus0.out_op); end
    total++; if (level0 !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level0); end
    total++; if (accepted0 !== 8'd1) begin bad++; $display("FAIL single_accepted got=%0d exp=1", accepted0); end
    tick();
    total++; if (bus0.out_data !== 4'b0001) begin bad++; $display("FAIL single_hold got=%b exp=0001", bus0.out_data); end
  endtask

  task automatic test_order();
    logic [3:0] exp_d [3];
    logic       exp_o [3];
    exp_d[0] = 4'b1001; exp_o[0] = 1'b1;
    exp_d[1] = 4'b0010; exp_o[1] = 1'b0;
    exp_d[2] = 4'b0110; exp_o[2] = 1'b1;
    do_reset();
    drive0(1'b1, 1'b1, 4'b0001, 4'b1001); tick();
    drive0(1'b1, 1'b0, 4'b0010, 4'b1001); tick();
    drive0(1'b1, 1'b1, 4'b0000, 4'b0110); tick();
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus0.out_data !== exp_d[i]) begin bad++; $display("FAIL order_data[%0d] got=%b exp=%b", i, bus0.out_data, exp_d[i]); end
      total++; if (bus0.out_op !== exp_o[i]) begin bad++; $display("FAIL order_op[%0d] got=%b exp=%b", i, bus0.out_op, exp_o[i]); end
      tick();
    end
    bus0.out_ready = 1'b0;
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL order_empty got=%b exp=0", bus0.out_valid); end
    total++; if (level0 !== 3'd0) begin bad++; $display("FAIL order_level got=%0d exp=0", level0); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive0(1'b1, 1'b0, 4'(i), 4'd0);
      tick();
      total++; if (bus0.in_ready !== (i < 4)) begin bad++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, bus0.in_ready, (i < 4)); end
      total++; if (level0 !== 3'((i < 4) ? i : 4)) begin bad++; $display("FAIL full_level[%0d] got=%0d exp=%0d", i, level0, (i < 4) ? i : 4); end
    end
    total++; if (accepted0 !== 8'd4) begin bad++; $display("FAIL full_accepted got=%0d exp=4", accepted0); end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    total++; if (level0 !== 3'd3) begin bad++; $display("FAIL full_pop_level got=%0d exp=3", level0); end
    total++; if (accepted0 !== 8'd4) begin bad++; $display("FAIL full_pop_accepted got=%0d exp=4", accepted0); end
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_in_ready got=%b exp=1", bus0.in_ready); end
    tick();
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    total++; if (level0 !== 3'd4) begin bad++; $display("FAIL full_refill_level got=%0d exp=4", level0); end
    total++; if (accepted0 !== 8'd5) begin bad++; $display("FAIL full_refill_accepted got=%0d exp=5", accepted0); end
    bus0.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      total++; if (bus0.out_data !== 4'(k)) begin bad++; $display("FAIL full_drain[%0d] got=%0d exp=%0d", k, bus0.out_data, k); end
      tick();
    end
    bus0.out_ready = 1'b0;
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL full_drain_empty got=%b exp=0", bus0.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive0(1'b1, 1'b0, 4'd0, 4'd0); tick();
    drive0(1'b1, 1'b0, 4'd1, 4'd0); tick();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 1'b0, 4'(i + 2), 4'd0);
      total++; if (bus0.out_data !== 4'(i)) begin bad++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, bus0.out_data, i); end
      tick();
      total++; if (level0 !== 3'd2) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level0); end
    end
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b0;
    total++; if (bus0.out_data !== 4'd6) begin bad++; $display("FAIL b2b_head got=%0d exp=6", bus0.out_data); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 1'b1, 4'd0, 4'(9 + i));
      tick();
    end
    total++; if (level0 !== 3'd3) begin bad++; $display("FAIL mid_pre_level got=%0d exp=3", level0); end
    rst = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b0;
    total++; if (level0 !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level0); end
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", bus0.out_valid); end
    total++; if (bus0.out_data !== 4'd0) begin bad++; $display("FAIL mid_out_data got=%b exp=0000", bus0.out_data); end
    total++; if (accepted0 !== 8'd0) begin bad++; $display("FAIL mid_accepted got=%0d exp=0", accepted0); end
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", bus0.in_ready); end
  endtask

  task automatic test_saturation();
    int exp_acc;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus1.in_valid = 1'b1;
      bus1.op_sel   = 1'($urandom_range(0, 1));
      bus1.nand_AB  = {2'b00, 2'($urandom)};
      bus1.not_A    = 4'($urandom);
      tick();
      bus1.in_valid = 1'b0;
      exp_acc = (i + 1 > 7) ? 7 : i + 1;
      total++; if (accepted1 !== 3'(exp_acc)) begin bad++; $display("FAIL sat_acc[%0d] got=%0d exp=%0d", i, accepted1, exp_acc); end
      total++; if (bus1.out_data !== q1[0].d) begin bad++; $display("FAIL sat_data[%0d] got=%b exp=%b", i, bus1.out_data, q1[0].d); end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
    end
    tick();
    tick();
    total++; if (accepted1 !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", accepted1); end
    total++; if (acc1 != 7) begin bad++; $display("FAIL sat_model got=%0d exp=7", acc1); end
  endtask

  task automatic test_random();
    logic [1:0] a, b;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      a = 2'($urandom);
      b = 2'($urandom);
      drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {2'b00, ~(a & b)}, {a, ~a});
      bus0.out_ready = 1'($urandom_range(0, 2) == 0);
      tick();
      total++; if (level0 !== 3'(q0.size())) begin bad++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", c, level0, q0.size()); end
      total++; if (bus0.out_valid !== (q0.size() != 0)) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b", c, bus0.out_valid); end
      total++; if (bus0.in_ready !== (q0.size() != DEPTH)) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b", c, bus0.in_ready); end
      total++; if (accepted0 !== 8'(acc0)) begin bad++; $display("FAIL rnd_accepted[%0d] got=%0d exp=%0d", c, accepted0, acc0); end
      if (q0.size() != 0) begin
        total++; if ({bus0.out_op, bus0.out_data} !== q0[0]) begin bad++; $display("FAIL rnd_head[%0d] got=%b/%b exp=%b/%b", c, bus0.out_op, bus0.out_data, q0[0].op, q0[0].d); end
      end else begin
        total++; if ({bus0.out_op, bus0.out_data} !== 5'd0) begin bad++; $display("FAIL rnd_empty_head[%0d] got=%b/%b exp=0/0000", c, bus0.out_op, bus0.out_data); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, 1'b0, 4'd0, 4'd0);
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.op_sel    = 1'b0;
    bus1.nand_AB   = 4'd0;
    bus1.not_A     = 4'd0;
    bus1.out_ready = 1'b0;
    acc0 = 0;
    acc1 = 0;
    test_reset();
    test_single_push();
    test_order();
    test_full();
    test_back_to_back();
    test_midstream_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_result_fifo.md
Name: logic_result_fifo

Overview:
- Downstream stage of the 2-bit logic unit. Each cycle it may capture one 4-bit result: either the NAND result or the NOT result, chosen by op_sel.
- Captured results are buffered in a DEPTH-entry first-word-fall-through FIFO, tagged with the op that produced them.
- Results are handed to the display/consumer stage over a valid/ready handshake.
- Decouples the combinational logic unit from a slower consumer (LED/7-seg scanner or serial shifter).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- PTR_W, 2, pointer width = log2(DEPTH).
- CNT_W, 8, width of accepted-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a result this cycle.
- in_ready  output  1  FIFO can accept (not full).
- op_sel  input  1  0 = take nand_AB, 1 = take not_A.
- nand_AB  input  4  NAND result from logic unit (bits [3:2] are 0 by construction).
- not_A  input  4  NOT result from logic unit ({A, ~A}).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  4  head result.
- out_op  output  1  op_sel tag stored with head.
- level  output  PTR_W+1  current occupancy, 0..DEPTH.
- accepted  output  CNT_W  saturating count of accepted pushes.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wr_ptr, rd_ptr and level cleared to 0.
  - accepted = 0; out_valid = 0; out_data = 0; out_op = 0.
  - in_ready = 1 from the first cycle after reset.
  - Memory contents are not cleared.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all entries.
- Input mux (combinational): din = op_sel ? not_A : nand_AB; tag = op_sel.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the rising edge.
- in_ready = (level != DEPTH). It depends only on registered level, never on out_ready, so there is no combinational ready path.
- out_valid = (level != 0).
- out_data/out_op = mem[rd_ptr] when out_valid, else 4'b0 / 0.
- Latency: a push at edge N is visible at out_valid/out_data after edge N. Zero-cycle bypass is not allowed.
- Ordering is strict FIFO.
- Each accepted entry is presented exactly once. Holding out_ready=0 keeps out_data stable.
- Level and pointer updates:
  - push only: level+1, wr_ptr+1.
  - pop only: level-1, rd_ptr+1.
  - push and pop together: level unchanged, both pointers advance.
  - This applies at any level 1..DEPTH-1.
- Full (level=DEPTH): in_ready=0 and the push is refused even if a pop happens in the same cycle. in_ready returns to 1 the cycle after the pop.
- Empty (level=0): out_valid=0, so out_ready is ignored and pop cannot occur.
- Pointers wrap modulo DEPTH with no skipped entries.
- accepted increments on each push and saturates at 2^CNT_W-1 (no wrap).
- Producer contract: hold din and op_sel stable while in_valid=1 and in_ready=0. The FIFO does not check this.
- State summary: EMPTY (level 0), PARTIAL (1..DEPTH-1), FULL (DEPTH). The states are derived from level; no separate FSM register.

Test Plan:
- Reset then single push: A=2'b10, B=2'b11, so nand_AB=4'b0001 and not_A=4'b1001. With op_sel=0, in_valid=1 for one cycle and out_ready=0, require after the edge: out_valid=1, out_data=4'b0001, out_op=0, level=1, accepted=1.
- Order and tags: push not_A=4'b1001 (op 1), then nand_AB=4'b0010 (op 0), then not_A=4'b0110 (op 1). Then assert out_ready=1. Require out_data sequence 1001, 0010, 0110 with tags 1, 0, 1, then out_valid=0 and level=0.
- Full: with out_ready=0, push 5 times. Require in_ready=0 after the 4th accepted push, level=4, accepted=4, and the 5th value absent. Then pop once with in_valid=1 held. Require no push in the pop cycle, then in_ready=1 and the held value accepted next edge.
- Simultaneous push/pop at level=2 over 6 cycles, values 0..5. Require level to stay 2 and output values to stay in order, exercising pointer wrap past entry 3.
- Mid-stream reset: at level=3, assert rst=1 together with in_valid=1 and out_ready=1. Require after the edge: level=0, out_valid=0, out_data=0, accepted=0, in_ready=1.
- Saturation (CNT_W=3 override): 10 accepted pushes interleaved with pops. Require accepted=7 and holding.
